// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath width defaults and FSM state encodings.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_BITS_DEF  = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_READY = 2'b01
  } state_e;

  // Opcodes 10..14 are reserved and, like NOP, leave the result register alone.
  function automatic logic op_updates_result(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

  function automatic logic op_updates_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational ALU for the execute datapath; carry_out is the bit above the result
// for ADD/SUB/ADDI (borrow for SUB) and zero otherwise.
module exec_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] y,
  output logic             carry_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Operation decode.
  always_comb begin
    y         = '0;
    carry_out = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: {carry_out, y} = sum;
      OP_SUB:          {carry_out, y} = diff;
      OP_AND:          y = a & b;
      OP_OR:           y = a | b;
      OP_XOR:          y = a ^ b;
      OP_NOT:          y = ~a;
      OP_SHL:          y = a << b[2:0];
      OP_SHR:          y = a >> b[2:0];
      OP_SLT:          y = {{(WIDTH-1){1'b0}}, (a < b)};
      default:         y = '0;
    endcase
  end

endmodule

// File: rtl/datapath_exec_unit.sv
// Execute/memory/writeback datapath beside the CU: ALU result register with flags, a small
// data memory self-initialised to mem[i]=i after reset, and the writeback mux onto result2.
module datapath_exec_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry,
  output logic                  busy
);

  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(MEM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  init_ptr_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic                  zero_q;
  logic                  carry_q;
  logic                  init_we;
  logic                  ready;

  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_c;
  logic [ADDR_BITS-1:0]  addr;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ADDI always takes the immediate, whatever sel3 says.
  assign alu_b = (sel3 || (opcode == OP_ADDI)) ? offset : operand2;
  assign addr  = alu_q[ADDR_BITS-1:0];

  exec_alu #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .a         (operand1),
    .b         (alu_b),
    .opcode    (opcode),
    .y         (alu_y),
    .carry_out (alu_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // Next state: leave INIT on the edge that writes the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_ptr_q == LastAddr) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy    = 1'b1;
    init_we = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
      end
      ST_READY: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Initialisation pointer walks the whole memory once per reset.
  always_ff @(posedge clk) begin
    if (!rst)         init_ptr_q <= '0;
    else if (init_we) init_ptr_q <= init_ptr_q + 1'b1;
  end

  // Result register and flags; NOP/reserved opcodes hold everything, carry only moves on add/sub.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else if (ready && op_updates_result(opcode)) begin
      alu_q  <= alu_y;
      zero_q <= (alu_y == '0);
      if (op_updates_carry(opcode)) carry_q <= alu_c;
    end
  end

  // Memory write port: init pattern while busy, store data once ready; nothing during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (init_we)          mem[init_ptr_q] <= DATA_WIDTH'(init_ptr_q);
      else if (ready && w_r) mem[addr]      <= operand2;
    end
  end

  // Writeback mux with asynchronous memory read.
  always_comb begin
    result2 = '0;
    if (!busy) result2 = sel1 ? alu_q : mem[addr];
  end

  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_datapath_exec_unit.sv
// Directed bench for datapath_exec_unit: a behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_datapath_exec_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] operand1, operand2, offset;
  logic [3:0] opcode;
  logic       sel1, sel3, w_r;
  logic [7:0] result2;
  logic       zero, carry, busy;

  int n_checks = 0;
  int n_pass   = 0;

  datapath_exec_unit dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model state.
  int mem_m [32];
  int alu_m, zero_m, carry_m, init_left;
  bit started = 0;

  // Model: update at each rising edge from the inputs the DUT sees.
  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b0) begin
        for (int i = 0; i < 32; i++) mem_m[i] = i;
        alu_m = 0; zero_m = 1; carry_m = 0; init_left = 32; started = 1;
      end else if (started) begin
        if (init_left > 0) begin
          init_left--;
        end else begin
          int a, b, r, op;
          bit upd, cupd;
          int c;
          if (w_r) mem_m[alu_m % 32] = operand2;
          a = operand1;
          b = (sel3 || opcode == 4'd8) ? int'(offset) : int'(operand2);
          op = opcode;
          upd = 1; cupd = 0; c = 0; r = 0;
          case (op)
            0, 8: begin r = a + b; c = (r > 255); r = r % 256; cupd = 1; end
            1:    begin c = (a < b); r = (a - b + 256) % 256; cupd = 1; end
            2:    r = a & b;
            3:    r = a | b;
            4:    r = a ^ b;
            5:    r = 255 - a;
            6:    r = (a * (1 << (b % 8))) % 256;
            7:    r = a / (1 << (b % 8));
            9:    r = (a < b) ? 1 : 0;
            default: upd = 0;
          endcase
          if (upd) begin
            alu_m = r; zero_m = (r == 0);
            if (cupd) carry_m = c;
          end
        end
      end
    end
  end

  // Compare DUT against model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        int exp_r;
        exp_r = (init_left > 0) ? 0 : (sel1 ? alu_m : mem_m[alu_m % 32]);
        check("model_busy", 32'(busy), 32'(init_left > 0));
        check("model_result2", 32'(result2), 32'(exp_r));
        check("model_zero", 32'(zero), 32'(zero_m));
        check("model_carry", 32'(carry), 32'(carry_m));
      end
    end
  end

  // Apply one set of controls across one rising edge; returns 2 time units after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] off,
                      input logic [3:0] op, input logic s1, input logic s3, input logic wr);
    operand1 = a; operand2 = b; offset = off; opcode = op;
    sel1 = s1; sel3 = s3; w_r = wr;
    @(posedge clk);
    #2;
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b0;
    operand1 = '0; operand2 = '0; offset = '0; opcode = OP_NOP;
    sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_result2", 32'(result2), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_carry", 32'(carry), 32'd0);
    rst = 1'b1;

    // Initialisation length.
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      step(8'd0, 8'd0, 8'd0, OP_NOP, 1'b1, 1'b0, 1'b0);
    end
    check("init_busy_cycles", 32'(busy_cnt), 32'd32);
    step(8'd7, 8'd0, 8'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("init_mem7", 32'(result2), 32'd7);
    step(8'd31, 8'd0, 8'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("init_mem31", 32'(result2), 32'd31);

    // ADD with carry out.
    step(8'd200, 8'd100, 8'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
    check("add_result", 32'(result2), 32'd44);
    check("add_carry", 32'(carry), 32'd1);
    check("add_zero", 32'(zero), 32'd0);

    // Store A5 to address 3+4, then load it back.
    step(8'd3, 8'hA5, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b0);
    step(8'd3, 8'hA5, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b1);
    step(8'd3, 8'hA5, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b1);
    step(8'd3, 8'h11, 8'd4, OP_ADD, 1'b0, 1'b1, 1'b0);
    check("store_load_mem7", 32'(result2), 32'hA5);

    // Address wrap: 30+5=35 -> address 3.
    step(8'd30, 8'd0, 8'd5, OP_ADD, 1'b0, 1'b1, 1'b0);
    check("wrap_mem3", 32'(result2), 32'd3);

    // A mix of ops.
    step(8'd3, 8'd5, 8'd0, OP_SUB, 1'b1, 1'b0, 1'b0);
    check("sub_borrow_result", 32'(result2), 32'd254);
    check("sub_borrow_carry", 32'(carry), 32'd1);
    step(8'h81, 8'd3, 8'd0, OP_SHL, 1'b1, 1'b0, 1'b0);
    check("shl_result", 32'(result2), 32'h08);
    step(8'h80, 8'd9, 8'd0, OP_SHR, 1'b1, 1'b0, 1'b0);
    check("shr_result", 32'(result2), 32'h40);
    step(8'd3, 8'd5, 8'd0, OP_SLT, 1'b1, 1'b0, 1'b0);
    check("slt_result", 32'(result2), 32'd1);
    step(8'h0F, 8'd0, 8'd0, OP_NOT, 1'b1, 1'b0, 1'b0);
    check("not_result", 32'(result2), 32'hF0);
    step(8'd250, 8'd1, 8'd10, OP_ADDI, 1'b1, 1'b0, 1'b0);
    check("addi_result", 32'(result2), 32'd4);
    check("addi_carry", 32'(carry), 32'd1);
    step(8'hF0, 8'h3C, 8'd0, OP_AND, 1'b1, 1'b0, 1'b0);
    check("and_result", 32'(result2), 32'h30);
    check("and_carry_held", 32'(carry), 32'd1);
    step(8'h0F, 8'hF0, 8'd0, OP_XOR, 1'b1, 1'b0, 1'b0);
    check("xor_result", 32'(result2), 32'hFF);

    // NOP and reserved opcodes hold the result.
    step(8'd5, 8'd5, 8'd0, OP_SUB, 1'b1, 1'b0, 1'b0);
    check("sub_zero_result", 32'(result2), 32'd0);
    check("sub_zero_flag", 32'(zero), 32'd1);
    check("sub_zero_carry", 32'(carry), 32'd0);
    step(8'd9, 8'd1, 8'd0, OP_NOP, 1'b1, 1'b0, 1'b0);
    step(8'd77, 8'd2, 8'd0, OP_NOP, 1'b1, 1'b0, 1'b0);
    step(8'd200, 8'd200, 8'd0, OP_NOP, 1'b1, 1'b0, 1'b0);
    check("nop_hold_result", 32'(result2), 32'd0);
    check("nop_hold_zero", 32'(zero), 32'd1);
    step(8'd200, 8'd200, 8'd0, 4'd12, 1'b1, 1'b0, 1'b0);
    check("reserved_hold_result", 32'(result2), 32'd0);

    // Reset landing on a store edge: no write, memory reinitialised.
    step(8'd3, 8'h77, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b0);
    check("pre_reset_addr", 32'(result2), 32'd7);
    rst = 1'b0;
    step(8'd3, 8'h77, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b1);
    check("midreset_busy", 32'(busy), 32'd1);
    check("midreset_result2", 32'(result2), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) step(8'd3, 8'h77, 8'd4, OP_ADD, 1'b1, 1'b1, 1'b0);
    check("reinit_ready", 32'(busy), 32'd0);
    step(8'd7, 8'd0, 8'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("reinit_mem7", 32'(result2), 32'd7);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
